// File: rtl/field_packer_if.sv
// field_packer_if: field-in / packed-word-out handshake bundle.
// master drives fields and consumes words; slave is the packer.
interface field_packer_if #(
    parameter int FW = 2,
    parameter int NF = 5
);
    localparam int CW = $clog2(NF + 1);

    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_field;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [NF*FW-1:0]  out_word;
    logic [CW-1:0]     out_fields;
    logic              out_short;
    logic [7:0]        out_seq;

    modport master (
        output in_valid, in_field, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_fields,
        input  out_short, out_seq
    );

    modport slave (
        input  in_valid, in_field, in_last, out_ready,
        output in_ready, out_valid, out_word, out_fields,
        output out_short, out_seq
    );
endinterface

// File: rtl/field_packer.sv
// field_packer: packs NF serial FW-bit fields into one word, first
// field in the MSBs; in_last closes a short, zero-padded word.
module field_packer #(
    parameter int FW = 2,
    parameter int NF = 5
) (
    input logic        clk,
    input logic        rst_n,
    field_packer_if.slave bus
);
    localparam int CW = $clog2(NF + 1);
    localparam int WW = NF * FW;

    logic [CW-1:0] cnt;
    logic [WW-1:0] asm_q;
    logic [WW-1:0] merged;
    logic [7:0]    seq;

    logic          vld_q;
    logic [WW-1:0] word_q;
    logic [CW-1:0] flds_q;
    logic          short_q;
    logic [7:0]    oseq_q;

    logic          rdy;
    logic          accept;
    logic          at_end;
    logic          close;

    // Ready is a combinational path from out_ready so a draining
    // word and a closing field can share one cycle.
    assign rdy    = rst_n && (!vld_q || bus.out_ready);
    assign accept = bus.in_valid && rdy;
    assign at_end = (cnt == CW'(NF - 1));
    assign close  = accept && (at_end || bus.in_last);

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = vld_q;
    assign bus.out_word   = word_q;
    assign bus.out_fields = flds_q;
    assign bus.out_short  = short_q;
    assign bus.out_seq    = oseq_q;

    // Drop the incoming field into slot cnt; unwritten slots stay 0.
    always_comb begin
        merged = asm_q;
        for (int k = 0; k < NF; k++) begin
            if (CW'(k) == cnt) begin
                merged[(NF-k)*FW-1 -: FW] = bus.in_field;
            end
        end
    end

    // Assembly, word close and output register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            asm_q   <= '0;
            seq     <= '0;
            vld_q   <= 1'b0;
            word_q  <= '0;
            flds_q  <= '0;
            short_q <= 1'b0;
            oseq_q  <= '0;
        end else begin
            if (vld_q && bus.out_ready) begin
                vld_q <= 1'b0;
            end
            if (close) begin
                word_q  <= merged;
                flds_q  <= cnt + CW'(1);
                short_q <= !at_end;
                oseq_q  <= seq;
                seq     <= seq + 8'd1;
                vld_q   <= 1'b1;
                cnt     <= '0;
                asm_q   <= '0;
            end else if (accept) begin
                asm_q <= merged;
                cnt   <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed tests for field_packer (FW=2, NF=5),
// one task per scenario with hand-computed expected words.
module tb_field_packer;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   cyc;

    field_packer_if #(.FW(2), .NF(5)) bus ();

    field_packer #(.FW(2), .NF(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] f, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_field = f;
        bus.in_last  = l;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL send_timeout: in_ready=%b required 1",
                     bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_field  = 2'b11;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
        else passed++;
        total++;
        if (bus.out_word !== 10'h000)
            $display("FAIL rst_out_word: got %h want 000", bus.out_word);
        else passed++;
        total++;
        if (bus.out_fields !== 3'd0 || bus.out_seq !== 8'd0)
            $display("FAIL rst_fields_seq: got %0d/%0d want 0/0",
                     bus.out_fields, bus.out_seq);
        else passed++;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL rel_in_ready: got %b want 1", bus.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rel_out_valid: got %b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_full_word;
        bus.out_ready = 1'b1;
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h1B1)
            $display("FAIL full_word: got v=%b %h want v=1 1b1",
                     bus.out_valid, bus.out_word);
        else passed++;
        total++;
        if (bus.out_fields !== 3'd5 || bus.out_short !== 1'b0 ||
            bus.out_seq !== 8'd0)
            $display("FAIL full_meta: got f=%0d s=%b q=%0d want 5 0 0",
                     bus.out_fields, bus.out_short, bus.out_seq);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL full_one_cycle: got %b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_short_word;
        send(2'b11, 1'b0);
        send(2'b10, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h380)
            $display("FAIL short_word: got v=%b %h want v=1 380",
                     bus.out_valid, bus.out_word);
        else passed++;
        total++;
        if (bus.out_fields !== 3'd2 || bus.out_short !== 1'b1 ||
            bus.out_seq !== 8'd1)
            $display("FAIL short_meta: got f=%0d s=%b q=%0d want 2 1 1",
                     bus.out_fields, bus.out_short, bus.out_seq);
        else passed++;
        // Single-field word, closing while the previous one drains.
        send(2'b01, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h100 ||
            bus.out_fields !== 3'd1 || bus.out_seq !== 8'd2)
            $display("FAIL short_slot0: got v=%b %h f=%0d q=%0d want 1 100 1 2",
                     bus.out_valid, bus.out_word, bus.out_fields,
                     bus.out_seq);
        else passed++;
        // in_last on the final slot is a normal full word.
        repeat (4) send(2'b11, 1'b0);
        send(2'b11, 1'b1);
        total++;
        if (bus.out_word !== 10'h3FF || bus.out_fields !== 3'd5 ||
            bus.out_short !== 1'b0 || bus.out_seq !== 8'd3)
            $display("FAIL last_on_full: got %h f=%0d s=%b q=%0d want 3ff 5 0 3",
                     bus.out_word, bus.out_fields, bus.out_short,
                     bus.out_seq);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        send(2'b00, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h06C ||
            bus.out_seq !== 8'd4)
            $display("FAIL bp_word: got v=%b %h q=%0d want 1 06c 4",
                     bus.out_valid, bus.out_word, bus.out_seq);
        else passed++;
        bus.in_valid = 1'b1;
        bus.in_field = 2'b10;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_word !== 10'h06C ||
                bus.out_valid !== 1'b1)
                $display("FAIL bp_hold%0d: got r=%b v=%b %h want 0 1 06c",
                         i, bus.in_ready, bus.out_valid, bus.out_word);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL bp_release: got %b want 1", bus.in_ready);
        else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL bp_drain: got %b want 0", bus.out_valid);
        else passed++;
        send(2'b01, 1'b0);
        send(2'b00, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        total++;
        if (bus.out_word !== 10'h241 || bus.out_seq !== 8'd5 ||
            bus.out_valid !== 1'b1)
            $display("FAIL bp_held_slot0: got v=%b %h q=%0d want 1 241 5",
                     bus.out_valid, bus.out_word, bus.out_seq);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int c0;
        int c1;
        bus.out_ready = 1'b1;
        repeat (5) send(2'b01, 1'b0);
        c0 = cyc;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h155 ||
            bus.out_seq !== 8'd6)
            $display("FAIL b2b_first: got v=%b %h q=%0d want 1 155 6",
                     bus.out_valid, bus.out_word, bus.out_seq);
        else passed++;
        repeat (5) send(2'b10, 1'b0);
        c1 = cyc;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h2AA ||
            bus.out_seq !== 8'd7)
            $display("FAIL b2b_second: got v=%b %h q=%0d want 1 2aa 7",
                     bus.out_valid, bus.out_word, bus.out_seq);
        else passed++;
        total++;
        if (c1 - c0 !== 5)
            $display("FAIL b2b_spacing: got %0d cycles want 5", c1 - c0);
        else passed++;
    endtask

    task automatic test_wrap_and_reset;
        logic [7:0] exp_seq;
        logic [1:0] f;
        exp_seq = 8'd8;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 257; w++) begin
            f = 2'(w);
            repeat (5) send(f, 1'b0);
            total++;
            if (bus.out_seq !== exp_seq || bus.out_word !== {5{f}})
                $display("FAIL wrap_w%0d: got q=%0d %h want q=%0d %h",
                         w, bus.out_seq, bus.out_word, exp_seq, {5{f}});
            else passed++;
            exp_seq = exp_seq + 8'd1;
        end
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL midreset: got v=%b r=%b want 0 0",
                     bus.out_valid, bus.in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b11, 1'b0);
        send(2'b00, 1'b0);
        send(2'b10, 1'b0);
        send(2'b01, 1'b0);
        send(2'b11, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 10'h327 ||
            bus.out_seq !== 8'd0 || bus.out_fields !== 3'd5 ||
            bus.out_short !== 1'b0)
            $display("FAIL post_reset: got v=%b %h q=%0d f=%0d s=%b want 1 327 0 5 0",
                     bus.out_valid, bus.out_word, bus.out_seq,
                     bus.out_fields, bus.out_short);
        else passed++;
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_field  = 2'b00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_short_word();
        test_backpressure();
        test_back_to_back();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
